pipelined_alu: RTL and testbench

PIPELINED_ALU -- requirements
Module: pipelined_alu

---
 rtl/pipelined_alu.sv | 191 +++++++++++++++++++
 tb/tb_pipelined_alu.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_alu.sv
// pipelined_alu: single-issue ALU with a valid/ready front end and a held,
// valid/ready result register. Single-cycle ops land in HOLD on the accept
// edge; multiply runs an iterative shift-add for WIDTH cycles before HOLD.
module pipelined_alu #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             carry,
   output logic             ovf,
   output logic             err
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_XOR  = 4'b0010;
   localparam logic [3:0] OP_OR   = 4'b0011;
   localparam logic [3:0] OP_AND  = 4'b0100;
   localparam logic [3:0] OP_NOT  = 4'b0101;
   localparam logic [3:0] OP_SLL  = 4'b0110;
   localparam logic [3:0] OP_SRL  = 4'b0111;
   localparam logic [3:0] OP_SLTU = 4'b1000;
   localparam logic [3:0] OP_MUL  = 4'b1001;
   localparam logic [3:0] OP_SLTS = 4'b1010;
   localparam logic [3:0] OP_SRA  = 4'b1011;

   typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;

   typedef struct packed {
      logic [WIDTH-1:0] res;
      logic             carry;
      logic             ovf;
      logic             err;
   } alu_resp_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             carry_q, carry_d;
   logic             ovf_q, ovf_d;
   logic             err_q, err_d;

   alu_resp_t        alu;
   logic [WIDTH:0]   add_w;
   logic [WIDTH:0]   sub_w;
   logic [SHW-1:0]   shamt;
   logic             accept;

   // Single-cycle datapath: result and flags for every non-mul opcode.
   always_comb begin
      alu   = '0;
      add_w = {1'b0, a} + {1'b0, b};
      sub_w = {1'b0, a} - {1'b0, b};   // top bit is the borrow (a < b unsigned)
      shamt = b[SHW-1:0];
      case (op)
         OP_ADD: begin
            alu.res   = add_w[WIDTH-1:0];
            alu.carry = add_w[WIDTH];
            alu.ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            alu.res   = sub_w[WIDTH-1:0];
            alu.carry = sub_w[WIDTH];
            alu.ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
         end
         OP_XOR:  alu.res = a ^ b;
         OP_OR:   alu.res = a | b;
         OP_AND:  alu.res = a & b;
         OP_NOT:  alu.res = ~a;
         OP_SLL:  alu.res = a << shamt;
         OP_SRL:  alu.res = a >> shamt;
         OP_SRA:  alu.res = $unsigned($signed(a) >>> shamt);
         OP_SLTU: alu.res = {{(WIDTH-1){1'b0}}, (a < b)};
         OP_SLTS: alu.res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_MUL:  alu.res = '0;          // handled by the iterative unit
         default: begin
            alu.res = '1;
            alu.err = 1'b1;
         end
      endcase
   end

   // Next-state, handshake and multiply-iteration logic.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      result_d  = result_q;
      carry_d   = carry_q;
      ovf_d     = ovf_q;
      err_d     = err_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      accept    = 1'b0;

      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            accept   = in_valid;
         end
         MUL: begin
            acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
            // last iteration goes straight to HOLD so mul takes WIDTH cycles
            if (cnt_q == CW'(1)) begin
               state_d  = HOLD;
               result_d = acc_d;
               carry_d  = 1'b0;
               ovf_d    = 1'b0;
               err_d    = 1'b0;
            end
         end
         HOLD: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
            if (out_ready) begin
               accept = in_valid;
               if (!in_valid) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (accept) begin
         if (op == OP_MUL) begin
            state_d  = MUL;
            cnt_d    = CW'(WIDTH);
            acc_d    = '0;
            mcand_d  = a;
            mplier_d = b;
         end else begin
            state_d  = HOLD;
            result_d = alu.res;
            carry_d  = alu.carry;
            ovf_d    = alu.ovf;
            err_d    = alu.err;
         end
      end
   end

   // State and datapath registers; reset wins over any handshake.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         result_q <= '0;
         carry_q  <= 1'b0;
         ovf_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         result_q <= result_d;
         carry_q  <= carry_d;
         ovf_q    <= ovf_d;
         err_q    <= err_d;
      end
   end

   assign result = result_q;
   assign zero   = (result_q == '0);
   assign carry  = carry_q;
   assign ovf    = ovf_q;
   assign err    = err_q;

endmodule

// File: tb/tb_pipelined_alu.sv
// Directed bench for pipelined_alu at WIDTH=32.
module tb_pipelined_alu;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [3:0]   op;
   logic [W-1:0] a, b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         zero, carry, ovf, err;

   int tests = 0;
   int fails = 0;

   pipelined_alu #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zero(zero), .carry(carry), .ovf(ovf), .err(err)
   );

   always #5 clk = ~clk;

   // arithmetic vectors: op, a, b, result, carry, ovf
   localparam logic [3:0]   AR_OP [6] = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h1};
   localparam logic [W-1:0] AR_A  [6] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd5, 32'd3, 32'h80000000};
   localparam logic [W-1:0] AR_B  [6] = '{32'd1, 32'd1, 32'd3, 32'd5, 32'd5, 32'd1};
   localparam logic [W-1:0] AR_R  [6] = '{32'h80000000, 32'h0, 32'd5, 32'h0, 32'hFFFFFFFE, 32'h7FFFFFFF};
   localparam logic         AR_C  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
   localparam logic         AR_V  [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

   // logic/shift/compare/undefined vectors: op, a, b, result, err
   localparam logic [3:0]   LG_OP [11] = '{4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hB, 4'hA, 4'h8, 4'hF, 4'hC};
   localparam logic [W-1:0] LG_A  [11] = '{32'hF0F01234, 32'hF0F01234, 32'hF0F01234, 32'hF0F01234,
                                           32'h1, 32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                           32'h12345678, 32'h0};
   localparam logic [W-1:0] LG_B  [11] = '{32'h0FF000FF, 32'h0FF000FF, 32'h0FF000FF, 32'h0FF000FF,
                                           32'h24, 32'h21, 32'h24, 32'h1, 32'h1, 32'h9, 32'h0};
   localparam logic [W-1:0] LG_R  [11] = '{32'hFF0012CB, 32'hFFF012FF, 32'h00F00034, 32'h0F0FEDCB,
                                           32'h10, 32'h40000000, 32'hF8000000, 32'h1, 32'h0,
                                           32'hFFFFFFFF, 32'hFFFFFFFF};
   localparam logic         LG_E  [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

   // advance one clock; outputs are then sampled 1 time unit after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // present one request from IDLE with out_ready low; returns in the cycle after acceptance
   task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      in_valid  = 1'b1;
      op        = o;
      a         = x;
      b         = y;
      out_ready = 1'b0;
      step();
      in_valid  = 1'b0;
   endtask

   // consume the held result and return to IDLE
   task automatic drain();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b1; op = 4'h0; a = 32'd1; b = 32'd1; out_ready = 1'b1;
      step();
      step();
      reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== '0 || zero !== 1'b1 ||
          carry !== 1'b0 || ovf !== 1'b0 || err !== 1'b0) begin
         fails++;
         $display("FAIL reset_state: got ov=%b ir=%b res=%h z=%b c=%b v=%b e=%b, want ov=0 ir=1 res=0 z=1 c=0 v=0 e=0",
                  out_valid, in_ready, result, zero, carry, ovf, err);
      end
   endtask

   task automatic test_arith();
      for (int i = 0; i < 6; i++) begin
         issue(AR_OP[i], AR_A[i], AR_B[i]);
         tests++;
         if (out_valid !== 1'b1 || result !== AR_R[i] || carry !== AR_C[i] || ovf !== AR_V[i] ||
             zero !== (AR_R[i] == '0) || err !== 1'b0) begin
            fails++;
            $display("FAIL arith[%0d]: got ov=%b res=%h c=%b v=%b z=%b e=%b, want ov=1 res=%h c=%b v=%b z=%b e=0",
                     i, out_valid, result, carry, ovf, zero, err, AR_R[i], AR_C[i], AR_V[i], AR_R[i] == '0);
         end
         drain();
      end
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         fails++;
         $display("FAIL arith_idle: got ov=%b ir=%b, want ov=0 ir=1", out_valid, in_ready);
      end
   endtask

   task automatic test_logic();
      for (int i = 0; i < 11; i++) begin
         issue(LG_OP[i], LG_A[i], LG_B[i]);
         tests++;
         if (out_valid !== 1'b1 || result !== LG_R[i] || err !== LG_E[i] ||
             carry !== 1'b0 || ovf !== 1'b0 || zero !== (LG_R[i] == '0)) begin
            fails++;
            $display("FAIL logic[%0d] op=%h: got ov=%b res=%h e=%b c=%b v=%b z=%b, want ov=1 res=%h e=%b c=0 v=0 z=%b",
                     i, LG_OP[i], out_valid, result, err, carry, ovf, zero, LG_R[i], LG_E[i], LG_R[i] == '0);
         end
         drain();
      end
   endtask

   task automatic test_mul(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] exp);
      int cyc = 0;
      int bad = 0;
      issue(4'h9, x, y);
      while (out_valid !== 1'b1 && cyc < 100) begin
         if (in_ready !== 1'b0) bad++;
         step();
         cyc++;
      end
      tests++;
      if (cyc != 32 || bad != 0) begin
         fails++;
         $display("FAIL mul_latency: got %0d busy cycles (%0d with in_ready high), want 32 (0)", cyc, bad);
      end
      tests++;
      if (out_valid !== 1'b1 || result !== exp || carry !== 1'b0 || ovf !== 1'b0 || err !== 1'b0 ||
          zero !== (exp == '0)) begin
         fails++;
         $display("FAIL mul_result: got ov=%b res=%h c=%b v=%b e=%b z=%b, want ov=1 res=%h c=0 v=0 e=0",
                  out_valid, result, carry, ovf, err, zero, exp);
      end
      drain();
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] xa [3] = '{32'h1, 32'hFFFF0000, 32'hAAAA5555};
      logic [W-1:0] xb [3] = '{32'h3, 32'h0000FFFF, 32'hAAAA5555};
      logic [W-1:0] xr [3] = '{32'h2, 32'hFFFFFFFF, 32'h0};
      int bad = 0;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      op        = 4'h2;
      for (int i = 0; i < 3; i++) begin
         a = xa[i];
         b = xb[i];
         step();
         tests++;
         if (out_valid !== 1'b1 || result !== xr[i] || zero !== (xr[i] == '0)) begin
            fails++;
            $display("FAIL b2b[%0d]: got ov=%b res=%h z=%b, want ov=1 res=%h z=%b",
                     i, out_valid, result, zero, xr[i], xr[i] == '0);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== xr[2] || zero !== 1'b1) bad++;
      end
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL stall_hold: got %0d stall cycles with changed outputs, want 0", bad);
      end
      drain();
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         fails++;
         $display("FAIL b2b_idle: got ov=%b ir=%b, want ov=0 ir=1", out_valid, in_ready);
      end
   endtask

   task automatic test_reset_mid_mul();
      int seen = 0;
      issue(4'h9, 32'h10000, 32'h10001);
      for (int i = 0; i < 9; i++) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      tests++;
      if (out_valid !== 1'b0 || zero !== 1'b1 || in_ready !== 1'b1 || result !== '0) begin
         fails++;
         $display("FAIL reset_mid_mul: got ov=%b z=%b ir=%b res=%h, want ov=0 z=1 ir=1 res=0",
                  out_valid, zero, in_ready, result);
      end
      issue(4'h0, 32'd2, 32'd3);
      tests++;
      if (out_valid !== 1'b1 || result !== 32'd5 || zero !== 1'b0) begin
         fails++;
         $display("FAIL add_after_reset: got ov=%b res=%h z=%b, want ov=1 res=00000005 z=0",
                  out_valid, result, zero);
      end
      drain();
      for (int i = 0; i < 40; i++) begin
         if (out_valid !== 1'b0) seen++;
         step();
      end
      tests++;
      if (seen != 0) begin
         fails++;
         $display("FAIL mul_discarded: got %0d cycles with out_valid after reset, want 0", seen);
      end
   endtask

   initial begin
      reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
      #1;
      test_reset();
      test_arith();
      test_logic();
      test_mul(32'h10000, 32'h10001, 32'h00010000);
      test_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
      test_mul(32'd7, 32'd6, 32'd42);
      test_back_to_back();
      test_reset_mid_mul();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
